// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle main control: opcodes, ALU operation
// codes consumed by the ALU decoder, controller states and opcode classes.
package mc_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_OR    = 3'b011;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b100;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BEQEX, S_IEX, S_IWB, S_JEX
  } state_t;

  typedef enum logic [2:0] {
    C_MEM, C_R, C_BEQ, C_J, C_IMM, C_BAD
  } opclass_t;

endpackage

// File: rtl/opclass.sv
// Combinational opcode classifier; also supplies the immediate-group ALU
// operation and the zero-extend select used in IEX/IWB.
module opclass
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]    op,
  output opclass_t           cls_c,
  output logic [ALUOP_W-1:0] imm_aluop_c,
  output logic               imm_extop_c
);

  always_comb begin
    cls_c       = C_BAD;
    imm_aluop_c = ALUOP_ADD;
    imm_extop_c = 1'b0;
    case (op)
      OP_LW, OP_SW: cls_c = C_MEM;
      OP_RTYPE:     cls_c = C_R;
      OP_BEQ:       cls_c = C_BEQ;
      OP_J:         cls_c = C_J;
      OP_ADDI:      cls_c = C_IMM;
      OP_SLTI: begin
        cls_c       = C_IMM;
        imm_aluop_c = ALUOP_SLT;
      end
      OP_ORI: begin
        cls_c       = C_IMM;
        imm_aluop_c = ALUOP_OR;
        imm_extop_c = 1'b1;
      end
      OP_LUI: begin
        cls_c       = C_IMM;
        imm_aluop_c = ALUOP_LUI;
        imm_extop_c = 1'b1;
      end
      default: cls_c = C_BAD;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main-control FSM: sequences each instruction, drives datapath
// enables and mux selects, and stalls on the memory ready handshake.
module mc_control
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               iord,
  output logic               alusrca,
  output logic               regdst,
  output logic               memtoreg,
  output logic               extop,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [ALUOP_W-1:0] aluop,
  output logic               irwrite,
  output logic               memwrite,
  output logic               regwrite,
  output logic               pcwrite,
  output logic               branch,
  output logic               pcen,
  output logic               illegal
);

  state_t               state;
  state_t               state_next;
  opclass_t             cls;
  logic [ALUOP_W-1:0]   imm_aluop;
  logic                 imm_extop;

  opclass u_opclass (
    .op          (op),
    .cls_c       (cls),
    .imm_aluop_c (imm_aluop),
    .imm_extop_c (imm_extop)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state: the IR is stable after FETCH, so op is re-read where needed.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_MEM:   state_next = S_MEMADR;
          C_R:     state_next = S_REX;
          C_BEQ:   state_next = S_BEQEX;
          C_J:     state_next = S_JEX;
          C_IMM:   state_next = S_IEX;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_REX:    state_next = S_RWB;
      S_IEX:    state_next = S_IWB;
      S_MEMWB, S_RWB, S_BEQEX, S_IWB, S_JEX: state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs: decoded from state; reset forces everything low in-cycle.
  always_comb begin
    iord     = 1'b0;
    alusrca  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    extop    = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          illegal = (cls == C_BAD);
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_REX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_RWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = 2'b01;
          branch  = 1'b1;
        end
        S_IEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          aluop   = imm_aluop;
          extop   = imm_extop;
        end
        S_IWB: begin
          regwrite = 1'b1;
          aluop    = imm_aluop;
          extop    = imm_extop;
        end
        S_JEX: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    pcen = pcwrite | (branch & zero);
  end

endmodule
